// File: rtl/register_bank_16x32_if.sv
// -----------------------------------------------------------------------------
// register_bank_16x32_if
//   Bus bundle for the 16x32 architectural register bank: the two write-back
//   ports, the PC load/increment controls, and the parallel register outputs.
//   Ports/signals:
//     we_a, wa_addr, wa_data   write port A (ALU/result path)
//     we_b, wb_addr, wb_data   write port B (base-register write-back)
//     pc_ld, pc_data, pc_inc   R15 branch load / auto-increment
//     regs_flat                {R15,...,R0}, Rn at [WIDTH*n +: WIDTH]
//     pc                       copy of R15
//     wr_conflict              one-cycle flag after a colliding write
//   Modports: master drives requests and observes state; slave is the bank.
// -----------------------------------------------------------------------------
interface register_bank_16x32_if #(
  parameter int WIDTH = 32
);
  logic                  we_a;
  logic [3:0]            wa_addr;
  logic [WIDTH-1:0]      wa_data;
  logic                  we_b;
  logic [3:0]            wb_addr;
  logic [WIDTH-1:0]      wb_data;
  logic                  pc_ld;
  logic [WIDTH-1:0]      pc_data;
  logic                  pc_inc;
  logic [16*WIDTH-1:0]   regs_flat;
  logic [WIDTH-1:0]      pc;
  logic                  wr_conflict;

  modport master (
    output we_a, wa_addr, wa_data,
    output we_b, wb_addr, wb_data,
    output pc_ld, pc_data, pc_inc,
    input  regs_flat, pc, wr_conflict
  );

  modport slave (
    input  we_a, wa_addr, wa_data,
    input  we_b, wb_addr, wb_data,
    input  pc_ld, pc_data, pc_inc,
    output regs_flat, pc, wr_conflict
  );
endinterface

// File: rtl/register_bank_16x32.sv
// -----------------------------------------------------------------------------
// register_bank_16x32
//   Architectural register bank R0..R15 with two write-back ports and a
//   dedicated PC path on R15 (branch load and auto-increment). All sixteen
//   registers are driven out in parallel straight from the flops, so a write
//   becomes visible only after the edge that samples it (no bypass).
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    register_bank_16x32_if.slave (write ports, PC controls, outputs)
//   Collision priority:
//     R0..R14 : port A > port B > hold
//     R15     : pc_ld > port A > port B > pc_inc > hold
//   wr_conflict reports a collision one cycle later; the priority winner is
//   always committed regardless.
// -----------------------------------------------------------------------------
module register_bank_16x32 #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(4)
) (
  input logic                   clk,
  input logic                   rst_n,
  register_bank_16x32_if.slave  bus
);

  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic             conflict_q;
  logic             conflict_d;

  logic             a_hits_pc;
  logic             b_hits_pc;

  assign a_hits_pc = bus.we_a && (bus.wa_addr == 4'hF);
  assign b_hits_pc = bus.we_b && (bus.wb_addr == 4'hF);

  // Next-state selection for the general-purpose registers and R15
  always_comb begin
    for (int n = 0; n < 15; n++) begin
      regs_d[n] = regs_q[n];
      if (bus.we_a && (bus.wa_addr == 4'(n))) begin
        regs_d[n] = bus.wa_data;
      end else if (bus.we_b && (bus.wb_addr == 4'(n))) begin
        regs_d[n] = bus.wb_data;
      end
    end

    regs_d[15] = regs_q[15];
    if (bus.pc_ld) begin
      regs_d[15] = bus.pc_data;
    end else if (a_hits_pc) begin
      regs_d[15] = bus.wa_data;
    end else if (b_hits_pc) begin
      regs_d[15] = bus.wb_data;
    end else if (bus.pc_inc) begin
      // Wraps modulo 2^WIDTH by truncation of the sum.
      regs_d[15] = regs_q[15] + PC_STEP;
    end
  end

  // Any request that loses to a higher-priority one counts as a collision.
  always_comb begin
    conflict_d = (bus.we_a && bus.we_b && (bus.wa_addr == bus.wb_addr))
               || (bus.pc_ld  && (a_hits_pc || b_hits_pc))
               || (bus.pc_inc && (a_hits_pc || b_hits_pc))
               || (bus.pc_ld  && bus.pc_inc);
  end

  // State update; reset wins over every write or PC request in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < 15; n++) begin
        regs_q[n] <= '0;
      end
      regs_q[15] <= PC_RESET;
      conflict_q <= 1'b0;
    end else begin
      for (int n = 0; n < 16; n++) begin
        regs_q[n] <= regs_d[n];
      end
      conflict_q <= conflict_d;
    end
  end

  // Outputs come straight from the flops
  for (genvar n = 0; n < 16; n++) begin : g_out
    assign bus.regs_flat[WIDTH*n +: WIDTH] = regs_q[n];
  end

  assign bus.pc          = regs_q[15];
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_register_bank_16x32.sv
module tb_register_bank_16x32;

  logic clk;
  logic rst_n;

  register_bank_16x32_if #(.WIDTH(32)) bus ();

  register_bank_16x32 #(
    .WIDTH    (32),
    .PC_RESET (32'h0),
    .PC_STEP  (32'h4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we_a;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic        we_b;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        pc_inc;
    int          chk_addr;
    logic [31:0] exp_old;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
    logic        exp_conf;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks;
  int errors;

  function automatic vec_t mk(
    input logic a, input logic [3:0] aa, input logic [31:0] ad,
    input logic b, input logic [3:0] ba, input logic [31:0] bd,
    input logic ld, input logic [31:0] ldd, input logic inc,
    input int ca, input logic [31:0] eo, input logic [31:0] ev,
    input logic [31:0] ep, input logic ec);
    vec_t v;
    v.we_a = a;  v.wa_addr = aa; v.wa_data = ad;
    v.we_b = b;  v.wb_addr = ba; v.wb_data = bd;
    v.pc_ld = ld; v.pc_data = ldd; v.pc_inc = inc;
    v.chk_addr = ca; v.exp_old = eo; v.exp_val = ev;
    v.exp_pc = ep; v.exp_conf = ec;
    return v;
  endfunction

  function automatic logic [31:0] rd(input int n);
    return bus.regs_flat[32*n +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.we_a = v.we_a; bus.wa_addr = v.wa_addr; bus.wa_data = v.wa_data;
    bus.we_b = v.we_b; bus.wb_addr = v.wb_addr; bus.wb_data = v.wb_data;
    bus.pc_ld = v.pc_ld; bus.pc_data = v.pc_data; bus.pc_inc = v.pc_inc;
  endtask

  task automatic idle();
    bus.we_a = 1'b0; bus.wa_addr = 4'h0; bus.wa_data = 32'h0;
    bus.we_b = 1'b0; bus.wb_addr = 4'h0; bus.wb_data = 32'h0;
    bus.pc_ld = 1'b0; bus.pc_data = 32'h0; bus.pc_inc = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //                a  aa    ad            b  ba    bd            ld ldd         inc ca  old           val           pc            conf
    vecs[0]  = mk(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0,        0, 32'h0,     0,  3,  32'h0,        32'hDEADBEEF, 32'h0,        0);
    vecs[1]  = mk(1, 4'd5, 32'h11,       1, 4'd5, 32'h22,       0, 32'h0,     0,  5,  32'h0,        32'h11,       32'h0,        1);
    vecs[2]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 32'h0,     0,  5,  32'h11,       32'h11,       32'h0,        0);
    vecs[3]  = mk(1, 4'd1, 32'hA,        1, 4'd2, 32'hB,        0, 32'h0,     0,  1,  32'h0,        32'hA,        32'h0,        0);
    vecs[4]  = mk(0, 4'd2, 32'hFFFF,     0, 4'd2, 32'hEEEE,     0, 32'h0,     0,  2,  32'hB,        32'hB,        32'h0,        0);
    vecs[5]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 32'h0,     1,  15, 32'h0,        32'h4,        32'h4,        0);
    vecs[6]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 32'h0,     1,  15, 32'h4,        32'h8,        32'h8,        0);
    vecs[7]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 32'h0,     1,  15, 32'h8,        32'hC,        32'hC,        0);
    vecs[8]  = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        1, 32'h100,   1,  15, 32'hC,        32'h100,      32'h100,      1);
    vecs[9]  = mk(1, 4'hF, 32'h200,      1, 4'hF, 32'h300,      0, 32'h0,     0,  15, 32'h100,      32'h200,      32'h200,      1);
    vecs[10] = mk(0, 4'd0, 32'h0,        1, 4'hF, 32'h400,      0, 32'h0,     1,  15, 32'h200,      32'h400,      32'h400,      1);
    vecs[11] = mk(1, 4'hF, 32'h600,      0, 4'd0, 32'h0,        1, 32'h500,   0,  15, 32'h400,      32'h500,      32'h500,      1);
    vecs[12] = mk(0, 4'd0, 32'h0,        1, 4'd9, 32'h99,       0, 32'h0,     0,  9,  32'h0,        32'h99,       32'h500,      0);
    vecs[13] = mk(0, 4'd9, 32'h5,        0, 4'd9, 32'h0,        0, 32'h777,   1,  9,  32'h99,       32'h99,       32'h504,      0);
    vecs[14] = mk(1, 4'd0, 32'h12345678, 0, 4'd0, 32'h0,        0, 32'h0,     0,  0,  32'h0,        32'h12345678, 32'h504,      0);
    vecs[15] = mk(1, 4'd14, 32'hCAFEF00D, 1, 4'hF, 32'hFFFFFFFC, 0, 32'h0,    0,  14, 32'h0,        32'hCAFEF00D, 32'hFFFFFFFC, 0);
    vecs[16] = mk(0, 4'd0, 32'h0,        0, 4'd0, 32'h0,        0, 32'h0,     1,  14, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        0);

    // Reset: every register cleared, PC at its reset value, no conflict
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    for (int n = 0; n < 15; n++) begin
      check($sformatf("reset_R%0d", n), rd(n), 32'h0);
    end
    check("reset_pc", bus.pc, 32'h0);
    check("reset_R15", rd(15), 32'h0);
    check("reset_conflict", {31'h0, bus.wr_conflict}, 32'h0);
    rst_n = 1'b1;

    // Table-driven vectors; each also confirms the pre-edge value is the old one
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_old_R%0d", i, vecs[i].chk_addr), rd(vecs[i].chk_addr), vecs[i].exp_old);
      tick();
      check($sformatf("v%0d_R%0d", i, vecs[i].chk_addr), rd(vecs[i].chk_addr), vecs[i].exp_val);
      check($sformatf("v%0d_pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("v%0d_conflict", i), {31'h0, bus.wr_conflict}, {31'h0, vecs[i].exp_conf});
    end

    // Accumulated state after the table: both same-cycle writes landed
    idle();
    check("post_R1", rd(1), 32'hA);
    check("post_R2", rd(2), 32'hB);
    check("post_R3", rd(3), 32'hDEADBEEF);
    check("post_R5", rd(5), 32'h11);

    // Reset arriving mid-operation drops pending writes and conflict
    bus.we_a = 1'b1; bus.wa_addr = 4'd7; bus.wa_data = 32'h70;
    bus.pc_ld = 1'b1; bus.pc_data = 32'h80; bus.pc_inc = 1'b1;
    tick();
    check("pre_rst_R7", rd(7), 32'h70);
    check("pre_rst_pc", bus.pc, 32'h80);
    check("pre_rst_conflict", {31'h0, bus.wr_conflict}, 32'h1);

    bus.we_a = 1'b1; bus.wa_addr = 4'd7; bus.wa_data = 32'h77;
    bus.we_b = 1'b1; bus.wb_addr = 4'hF; bus.wb_data = 32'h1234;
    bus.pc_ld = 1'b0; bus.pc_inc = 1'b1;
    rst_n = 1'b0;
    tick();
    check("midrst_R7", rd(7), 32'h0);
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_R3", rd(3), 32'h0);
    check("midrst_conflict", {31'h0, bus.wr_conflict}, 32'h0);

    rst_n = 1'b1;
    idle();
    tick();
    check("after_rst_R7", rd(7), 32'h0);
    check("after_rst_pc", bus.pc, 32'h0);
    check("after_rst_R14", rd(14), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
